fft_out_collector: RTL and testbench
====================================

Name: fft_out_collector

Overview:
- Receiver for the FFT chip's serial output pin stream.
- Accepts one 34-bit complex word per valid cycle: 17-bit real in [33:17], 17-bit imag in [16:0]. Treats the word as opaque.
- Undoes the bit-reversed output order of the in-place radix-2 core and buffers whole frames in a ping-pong pair of banks.
- Presents frames in natural order on a valid/ready stream toward the host or capture logic.

Parameters:
- N_POINTS, 8, points per frame; must be a power of 2.
- LOG2N, 3, log2(N_POINTS); sets the index width.
- WORD_W, 34, complex word width.
- REORDER, 1, 1 = bit-reversed write addressing; 0 = natural addressing.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  in_data holds a valid FFT output word this cycle.
- in_sof  in  1  qualifies in_data as frame word 0; ignored when in_valid=0.
- in_data  in  WORD_W  FFT output word.
- out_valid  out  1  out_data holds a valid natural-order word.
- out_ready  in  1  downstream accepts the word.
- out_data  out  WORD_W  reordered word.
- out_index  out  LOG2N  natural-order bin index of out_data.
- out_last  out  1  high with bin N_POINTS-1.
- frame_count  out  16  count of frames fully drained; wraps modulo 2^16.
- overflow  out  1  sticky; a frame was dropped because both banks were full.
- sync_err  out  1  one-cycle pulse; in_sof arrived mid-frame.

Behaviour:
- Reset (rst=1 at an edge):
  - Every output goes to 0.
  - wr_cnt=0, rd_cnt=0, wr_bank=0, rd_bank=0, both bank-full flags=0.
  - Write FSM goes to IDLE. A partially written or partially drained frame is discarded.
  - Reset wins over any simultaneous input event.
- Storage: 2 banks × N_POINTS × WORD_W registers.
- Write address:
  - REORDER=1: bit-reverse of wr_cnt over LOG2N bits (e.g. N=8: 0,4,2,6,1,5,3,7).
  - REORDER=0: wr_cnt.
- Write FSM states: IDLE, FILL, DROP.
- IDLE:
  - in_valid=1 and in_sof=1, with bank wr_bank not full: write word 0, wr_cnt←1, go to FILL.
  - in_valid=1 and in_sof=1, with bank wr_bank full: overflow←1, go to DROP.
  - in_valid=1 with in_sof=0: word ignored.
- FILL, each in_valid=1 without sof: write at addr(wr_cnt), wr_cnt++.
- FILL, on the write with wr_cnt=N_POINTS-1:
  - Set full[wr_bank].
  - Toggle wr_bank.
  - Set wr_cnt←0 and go to IDLE.
- FILL, in_valid=1 with in_sof=1 while wr_cnt≠0:
  - Pulse sync_err for one cycle.
  - Discard the partial frame; the bank stays not-full.
  - Treat the sof word as the new word 0 (write it, wr_cnt←1).
- DROP: ignore words until the next in_valid with in_sof=1, then handle it exactly as in IDLE.
- overflow clears only on reset.
- Full-flag timing: flags are sampled before the edge's updates. A bank freed by the read side on the same edge as an sof targeting it counts as full, so that frame is dropped.
- Read side:
  - out_data, out_index and out_last are registered.
  - When full[rd_bank]=1 and the output register is empty, load mem[rd_bank][0], out_index=0, out_valid←1.
  - out_valid rises exactly 2 edges after the edge that captured the last input word, provided that bank was next to drain.
  - While out_valid=1 and out_ready=0, all outputs hold stable.
- Read transfer (out_valid=1 and out_ready=1):
  - If rd_cnt<N_POINTS-1: load the next word on the same edge, rd_cnt++. Throughput is 1 word/cycle with no bubbles inside a frame.
  - If rd_cnt=N_POINTS-1 (out_last=1): clear full[rd_bank], toggle rd_bank, rd_cnt←0, frame_count++, out_valid←0.
  - Between frames there is exactly one cycle of out_valid=0, even if the other bank is already full.
- Write and read on different banks in the same cycle are independent; both take effect.

Test Plan:
1. Single frame: after reset, in_sof+in_valid on words W0..W7 = 0x100+k in consecutive cycles, out_ready=1 → out_valid high 2 edges after W7. Output order is 0x100,0x104,0x102,0x106,0x101,0x105,0x103,0x107 with out_index 0..7, out_last on the 8th word, frame_count=1.
2. Backpressure: same frame with out_ready toggled 1,0,0,1,... → each word holds stable while stalled, no word lost or duplicated, output order as in test 1.
3. Overflow: out_ready=0, send 3 complete frames → frames 1 and 2 stored, frame 3 dropped with overflow=1. Raise out_ready → exactly 16 words (frames 1, 2) with one idle cycle between them, frame_count=2, overflow still 1.
4. Sync error: sof plus 3 words, then a new sof frame of 8 words → sync_err pulses 1 cycle on the second sof, and only the second frame is output.
5. Reset mid-operation: assert rst during the 5th output word → all outputs 0 next cycle, frame_count=0. A fresh frame afterward is output correctly.
6. REORDER=0, N_POINTS=16: 16 words in → output in arrival order, out_index 0..15.

Source files
------------

// File: rtl/fft_out_collector.sv
`default_nettype none
// ============================================================================
// Module      : fft_out_collector
// Description : Collects the FFT core's serial output words, undoes the
//               bit-reversed output order and buffers whole frames in two
//               ping-pong banks. Frames leave in natural bin order on a
//               valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_out_collector #(
    parameter int N_POINTS = 8,
    parameter int LOG2N    = 3,
    parameter int WORD_W   = 34,
    parameter int REORDER  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [LOG2N-1:0]  out_index,
    output logic              out_last,
    output logic [15:0]       frame_count,
    output logic              overflow,
    output logic              sync_err
);

    localparam logic [LOG2N-1:0] c_last_idx = LOG2N'(N_POINTS - 1);
    localparam logic [LOG2N-1:0] c_one      = LOG2N'(1);

    typedef enum logic [1:0] {
        c_st_idle = 2'd0,
        c_st_fill = 2'd1,
        c_st_drop = 2'd2
    } wr_state_t;

    // Frame storage: two banks of N_POINTS words
    logic [WORD_W-1:0] r_mem [2][N_POINTS];

    // Write side state
    wr_state_t        r_wr_state;
    wr_state_t        w_wr_state_nxt;
    logic [LOG2N-1:0] r_wr_cnt;
    logic [LOG2N-1:0] w_wr_cnt_nxt;
    logic             r_wr_bank;
    logic             r_overflow;
    logic             r_sync_err;

    logic             w_wr_en;
    logic [LOG2N-1:0] w_wr_idx;
    logic [LOG2N-1:0] w_wr_addr;
    logic             w_set_full;
    logic             w_set_ovf;
    logic             w_sync_err;
    logic             w_frame_start;

    // Bank full flags; r_full_d is the copy the read side acts on, which
    // places the first output word two edges after the frame completes.
    logic [1:0]       r_full;
    logic [1:0]       r_full_d;

    // Read side state
    logic [LOG2N-1:0] r_rd_cnt;
    logic             r_rd_bank;
    logic             r_out_valid;
    logic [WORD_W-1:0] r_out_data;
    logic             r_out_last;
    logic [15:0]      r_frame_count;

    logic [LOG2N-1:0] w_rd_next;
    logic             w_rd_xfer;
    logic             w_rd_done;
    logic             w_drain_go;

    assign w_frame_start = in_valid & in_sof;

    // Write address: bit-reversed for the in-place radix-2 output order
    if (REORDER != 0) begin : g_reorder
        for (genvar g = 0; g < LOG2N; g++) begin : g_bit
            assign w_wr_addr[g] = w_wr_idx[LOG2N-1-g];
        end
    end else begin : g_natural
        assign w_wr_addr = w_wr_idx;
    end

    // Write FSM state register and sticky/pulse status
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state <= c_st_idle;
            r_wr_cnt   <= '0;
            r_wr_bank  <= 1'b0;
            r_overflow <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_wr_cnt   <= w_wr_cnt_nxt;
            r_sync_err <= w_sync_err;
            if (w_set_full) r_wr_bank  <= ~r_wr_bank;
            if (w_set_ovf)  r_overflow <= 1'b1;
        end
    end

    // Write FSM next-state and write-port control
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_cnt_nxt   = r_wr_cnt;
        w_wr_en        = 1'b0;
        w_wr_idx       = r_wr_cnt;
        w_set_full     = 1'b0;
        w_set_ovf      = 1'b0;
        w_sync_err     = 1'b0;
        case (r_wr_state)
            c_st_idle, c_st_drop: begin
                if (w_frame_start) begin
                    if (!r_full[r_wr_bank]) begin
                        w_wr_en        = 1'b1;
                        w_wr_idx       = '0;
                        w_wr_cnt_nxt   = c_one;
                        w_wr_state_nxt = c_st_fill;
                    end else begin
                        w_set_ovf      = 1'b1;
                        w_wr_state_nxt = c_st_drop;
                    end
                end
            end
            c_st_fill: begin
                if (in_valid) begin
                    w_wr_en = 1'b1;
                    if (in_sof) begin
                        // Early sof: abandon the partial frame and restart
                        w_sync_err   = 1'b1;
                        w_wr_idx     = '0;
                        w_wr_cnt_nxt = c_one;
                    end else if (r_wr_cnt == c_last_idx) begin
                        w_set_full     = 1'b1;
                        w_wr_cnt_nxt   = '0;
                        w_wr_state_nxt = c_st_idle;
                    end else begin
                        w_wr_cnt_nxt = r_wr_cnt + c_one;
                    end
                end
            end
            default: begin
                w_wr_state_nxt = c_st_idle;
                w_wr_cnt_nxt   = '0;
            end
        endcase
    end

    // Bank storage write port
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_bank][w_wr_addr] <= in_data;
    end

    assign w_rd_next  = r_rd_cnt + c_one;
    assign w_rd_xfer  = r_out_valid & out_ready;
    assign w_rd_done  = w_rd_xfer & (r_rd_cnt == c_last_idx);
    assign w_drain_go = r_full[r_rd_bank] & r_full_d[r_rd_bank];

    // Full flags: set by the writer on frame completion, cleared by the
    // reader after the last word; the two always target different banks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full   <= 2'b00;
            r_full_d <= 2'b00;
        end else begin
            r_full_d <= r_full;
            if (w_set_full) r_full[r_wr_bank] <= 1'b1;
            if (w_rd_done)  r_full[r_rd_bank] <= 1'b0;
        end
    end

    // Read side: natural-order drain with a registered output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_cnt      <= '0;
            r_rd_bank     <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_last    <= 1'b0;
            r_frame_count <= '0;
        end else if (w_rd_xfer) begin
            if (r_rd_cnt == c_last_idx) begin
                r_rd_cnt      <= '0;
                r_rd_bank     <= ~r_rd_bank;
                r_frame_count <= r_frame_count + 16'd1;
                r_out_valid   <= 1'b0;
                r_out_last    <= 1'b0;
            end else begin
                r_rd_cnt   <= w_rd_next;
                r_out_data <= r_mem[r_rd_bank][w_rd_next];
                r_out_last <= (w_rd_next == c_last_idx);
            end
        end else if (!r_out_valid && w_drain_go) begin
            r_rd_cnt    <= '0;
            r_out_valid <= 1'b1;
            r_out_data  <= r_mem[r_rd_bank][0];
            r_out_last  <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_index   = r_rd_cnt;
    assign out_last    = r_out_last;
    assign frame_count = r_frame_count;
    assign overflow    = r_overflow;
    assign sync_err    = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_fft_out_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_out_collector
// Description : Directed self-checking bench for fft_out_collector. Instance
//               A uses the default bit-reversed 8-point setup, instance B a
//               16-point natural-order setup.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_out_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid_a = 1'b0;
    logic        in_sof_a   = 1'b0;
    logic [33:0] in_data_a  = '0;
    logic        out_ready_a = 1'b0;
    logic        out_valid_a;
    logic [33:0] out_data_a;
    logic [2:0]  out_index_a;
    logic        out_last_a;
    logic [15:0] frame_count_a;
    logic        overflow_a;
    logic        sync_err_a;

    logic        in_valid_b = 1'b0;
    logic        in_sof_b   = 1'b0;
    logic [33:0] in_data_b  = '0;
    logic        out_ready_b = 1'b0;
    logic        out_valid_b;
    logic [33:0] out_data_b;
    logic [3:0]  out_index_b;
    logic        out_last_b;
    logic [15:0] frame_count_b;
    logic        overflow_b;
    logic        sync_err_b;

    int n_vec = 0;
    int n_err = 0;

    // Position of input word k at natural output slot i (8-point bit reversal)
    logic [33:0] c_order [8] = '{34'd0, 34'd4, 34'd2, 34'd6, 34'd1, 34'd5, 34'd3, 34'd7};

    fft_out_collector #(.N_POINTS(8), .LOG2N(3), .WORD_W(34), .REORDER(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a), .in_sof(in_sof_a), .in_data(in_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .out_index(out_index_a), .out_last(out_last_a),
        .frame_count(frame_count_a), .overflow(overflow_a), .sync_err(sync_err_a)
    );

    fft_out_collector #(.N_POINTS(16), .LOG2N(4), .WORD_W(34), .REORDER(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_sof(in_sof_b), .in_data(in_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .out_index(out_index_b), .out_last(out_last_b),
        .frame_count(frame_count_b), .overflow(overflow_b), .sync_err(sync_err_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [33:0] base);
        for (int k = 0; k < 8; k++) begin
            in_valid_a = 1'b1;
            in_sof_a   = (k == 0);
            in_data_a  = base + 34'(k);
            tick();
        end
        in_valid_a = 1'b0;
        in_sof_a   = 1'b0;
    endtask

    task automatic wait_valid_a();
        int c = 0;
        while (!out_valid_a && c < 50) begin
            tick();
            c++;
        end
        chk("wait_valid", {63'd0, out_valid_a}, 64'd1);
    endtask

    // Drain one 8-word frame; stall=1 drives ready as 1,0,0,1,0,0,...
    task automatic drain_a(input logic [33:0] base, input bit stall);
        int got = 0;
        int cyc = 0;
        bit held = 1'b0;
        logic [33:0] hd = '0;
        logic [2:0]  hi = '0;
        while (got < 8 && cyc < 200) begin
            out_ready_a = stall ? (cyc % 3 == 0) : 1'b1;
            if (held) begin
                chk("hold_valid", {63'd0, out_valid_a}, 64'd1);
                chk("hold_data", {30'd0, out_data_a}, {30'd0, hd});
                chk("hold_index", {61'd0, out_index_a}, {61'd0, hi});
            end
            if (out_valid_a && out_ready_a) begin
                chk("out_data", {30'd0, out_data_a}, {30'd0, base + c_order[got]});
                chk("out_index", {61'd0, out_index_a}, 64'(got));
                chk("out_last", {63'd0, out_last_a}, (got == 7) ? 64'd1 : 64'd0);
                got++;
            end
            held = out_valid_a && !out_ready_a;
            hd   = out_data_a;
            hi   = out_index_a;
            tick();
            cyc++;
        end
        chk("drain_count", 64'(got), 64'd8);
        out_ready_a = 1'b1;
    endtask

    initial begin
        // Reset
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", {63'd0, out_valid_a}, 64'd0);
        chk("rst_data", {30'd0, out_data_a}, 64'd0);
        chk("rst_fcount", {48'd0, frame_count_a}, 64'd0);
        chk("rst_ovf", {63'd0, overflow_a}, 64'd0);
        chk("rst_serr", {63'd0, sync_err_a}, 64'd0);

        // 1: single frame, two-edge latency, bit-reversal undone
        out_ready_a = 1'b1;
        send_a(34'h100);
        chk("lat_e0", {63'd0, out_valid_a}, 64'd0);
        tick();
        chk("lat_e1", {63'd0, out_valid_a}, 64'd0);
        tick();
        chk("lat_e2", {63'd0, out_valid_a}, 64'd1);
        drain_a(34'h100, 1'b0);
        chk("t1_valid_low", {63'd0, out_valid_a}, 64'd0);
        chk("t1_fcount", {48'd0, frame_count_a}, 64'd1);

        // 2: backpressure
        out_ready_a = 1'b0;
        send_a(34'h200);
        wait_valid_a();
        drain_a(34'h200, 1'b1);
        chk("t2_fcount", {48'd0, frame_count_a}, 64'd2);

        // 3: overflow with both banks full
        out_ready_a = 1'b0;
        send_a(34'h300);
        send_a(34'h400);
        send_a(34'h500);
        tick();
        tick();
        tick();
        chk("t3_ovf", {63'd0, overflow_a}, 64'd1);
        chk("t3_held_valid", {63'd0, out_valid_a}, 64'd1);
        chk("t3_held_data", {30'd0, out_data_a}, 64'h300);
        out_ready_a = 1'b1;
        drain_a(34'h300, 1'b0);
        chk("t3_gap", {63'd0, out_valid_a}, 64'd0);
        tick();
        chk("t3_second_valid", {63'd0, out_valid_a}, 64'd1);
        chk("t3_second_data", {30'd0, out_data_a}, 64'h400);
        drain_a(34'h400, 1'b0);
        chk("t3_fcount", {48'd0, frame_count_a}, 64'd4);
        tick();
        tick();
        tick();
        chk("t3_no_frame3", {63'd0, out_valid_a}, 64'd0);
        chk("t3_ovf_sticky", {63'd0, overflow_a}, 64'd1);

        // 4: sof arriving mid-frame
        chk("t4_serr_idle", {63'd0, sync_err_a}, 64'd0);
        for (int k = 0; k < 4; k++) begin
            in_valid_a = 1'b1;
            in_sof_a   = (k == 0);
            in_data_a  = 34'h600 + 34'(k);
            tick();
        end
        chk("t4_serr_before", {63'd0, sync_err_a}, 64'd0);
        for (int k = 0; k < 8; k++) begin
            in_valid_a = 1'b1;
            in_sof_a   = (k == 0);
            in_data_a  = 34'h700 + 34'(k);
            tick();
            if (k == 0) chk("t4_serr_pulse", {63'd0, sync_err_a}, 64'd1);
            if (k == 1) chk("t4_serr_clear", {63'd0, sync_err_a}, 64'd0);
        end
        in_valid_a = 1'b0;
        in_sof_a   = 1'b0;
        tick();
        chk("t4_lat_e1", {63'd0, out_valid_a}, 64'd0);
        tick();
        chk("t4_lat_e2", {63'd0, out_valid_a}, 64'd1);
        drain_a(34'h700, 1'b0);
        chk("t4_fcount", {48'd0, frame_count_a}, 64'd5);
        tick();
        tick();
        tick();
        chk("t4_single_frame", {63'd0, out_valid_a}, 64'd0);

        // 5: reset during the fifth output word
        send_a(34'h800);
        wait_valid_a();
        tick();
        tick();
        tick();
        tick();
        chk("t5_index4", {61'd0, out_index_a}, 64'd4);
        chk("t5_data4", {30'd0, out_data_a}, 64'h801);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_valid", {63'd0, out_valid_a}, 64'd0);
        chk("t5_data", {30'd0, out_data_a}, 64'd0);
        chk("t5_index", {61'd0, out_index_a}, 64'd0);
        chk("t5_last", {63'd0, out_last_a}, 64'd0);
        chk("t5_fcount", {48'd0, frame_count_a}, 64'd0);
        chk("t5_ovf", {63'd0, overflow_a}, 64'd0);
        send_a(34'h900);
        tick();
        tick();
        chk("t5_fresh_valid", {63'd0, out_valid_a}, 64'd1);
        drain_a(34'h900, 1'b0);
        chk("t5_fresh_fcount", {48'd0, frame_count_a}, 64'd1);

        // 6: 16-point natural order
        out_ready_b = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_valid_b = 1'b1;
            in_sof_b   = (k == 0);
            in_data_b  = 34'hA00 + 34'(k);
            tick();
        end
        in_valid_b = 1'b0;
        in_sof_b   = 1'b0;
        tick();
        chk("t6_lat_e1", {63'd0, out_valid_b}, 64'd0);
        tick();
        for (int i = 0; i < 16; i++) begin
            chk("t6_valid", {63'd0, out_valid_b}, 64'd1);
            chk("t6_data", {30'd0, out_data_b}, 64'hA00 + 64'(i));
            chk("t6_index", {60'd0, out_index_b}, 64'(i));
            chk("t6_last", {63'd0, out_last_b}, (i == 15) ? 64'd1 : 64'd0);
            tick();
        end
        chk("t6_valid_low", {63'd0, out_valid_b}, 64'd0);
        chk("t6_fcount", {48'd0, frame_count_b}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
